// File: rtl/pipe_seq_pkg.sv
// Shared types for the pipeline sequencer: controller states, the per-cycle
// stage-control bundle and the canonical control patterns.
package pipe_seq_pkg;

    localparam int unsigned NUM_STAGE_REGS = 4;

    typedef enum logic [1:0] {
        RUN,
        MC_WAIT,
        DM_WAIT
    } pipe_seq_state_t;

    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic de_en;
        logic em_en;
        logic mw_en;
        logic fd_flush;
        logic de_flush;
        logic em_flush;
    } stage_ctrl_t;

    typedef logic [NUM_STAGE_REGS-1:0] reg_en_t;

    //                                           pc fd de em mw | fd de em flush
    localparam stage_ctrl_t CTRL_NORMAL  = 8'b1_1_1_1_1_0_0_0;
    localparam stage_ctrl_t CTRL_FREEZE  = 8'b0_0_0_0_0_0_0_0;
    localparam stage_ctrl_t CTRL_MC_HOLD = 8'b0_0_0_1_1_0_0_1;
    localparam stage_ctrl_t CTRL_RESET   = 8'b1_1_1_1_1_1_1_1;

    // Inter-stage register enables in pipeline order F->D, D->E, E->M, M->W.
    function automatic reg_en_t reg_enables(input stage_ctrl_t c);
        return {c.fd_en, c.de_en, c.em_en, c.mw_en};
    endfunction

    function automatic logic any_flush(input stage_ctrl_t c);
        return c.fd_flush | c.de_flush | c.em_flush;
    endfunction

endpackage

// File: rtl/pipe_seq_dm_timer.sv
// Data-memory wait timer: counts stalled DM cycles and raises a sticky
// timeout flag once the count reaches DM_TIMEOUT.
module pipe_seq_dm_timer #(
    parameter int unsigned DM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic hold,
    output logic timeout_err
);

    localparam int unsigned W = $clog2(DM_TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(DM_TIMEOUT);
    localparam logic [W-1:0] ONE   = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         err_q;

    // The stall cycle that enters the wait counts as the first wait cycle;
    // the dm_ready cycle is not a wait cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = ONE;
        end else if (hold && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_d == LIMIT) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = err_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush controller for the 5-stage pipeline.
// Define PIPE_SEQ_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_sequencer #(
    parameter int unsigned DM_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_stall_req,
    input  logic             ex_redirect,
    input  logic             ex_mc_op,
    input  logic             mc_done,
    input  logic             m_mem_req,
    input  logic             dm_ready,
    output logic             mc_start,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic             dm_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    import pipe_seq_pkg::*;

    pipe_seq_state_t state_q;
    pipe_seq_state_t state_d;
    stage_ctrl_t     ctrl;
    reg_en_t         reg_en;
    logic            eval_run;
    logic            chk_mc;
    logic            dm_start;
    logic            dm_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Completion cycles of either wait fall through to the RUN priority
    // chain; a finishing multi-cycle op must not restart itself.
    always_comb begin
        ctrl     = CTRL_NORMAL;
        mc_start = 1'b0;
        state_d  = state_q;
        dm_start = 1'b0;
        dm_hold  = 1'b0;
        eval_run = 1'b0;
        chk_mc   = 1'b1;

        case (state_q)
            RUN: begin
                eval_run = 1'b1;
            end
            DM_WAIT: begin
                if (dm_ready) begin
                    eval_run = 1'b1;
                end else begin
                    ctrl    = CTRL_FREEZE;
                    dm_hold = 1'b1;
                end
            end
            MC_WAIT: begin
                if (mc_done) begin
                    eval_run = 1'b1;
                    chk_mc   = 1'b0;
                end else begin
                    ctrl = CTRL_MC_HOLD;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (eval_run) begin
            state_d = RUN;
            if (m_mem_req && !dm_ready) begin
                ctrl     = CTRL_FREEZE;
                dm_start = 1'b1;
                state_d  = DM_WAIT;
            end else if (chk_mc && ex_mc_op) begin
                ctrl     = CTRL_MC_HOLD;
                mc_start = 1'b1;
                state_d  = MC_WAIT;
            end else if (ex_redirect) begin
                ctrl.fd_flush = 1'b1;
                ctrl.de_flush = 1'b1;
            end else if (hz_stall_req) begin
                ctrl.pc_en    = 1'b0;
                ctrl.fd_en    = 1'b0;
                ctrl.de_flush = 1'b1;
            end
        end

        // Reset drains the pipeline by clocking bubbles through every stage.
        if (rst) begin
            ctrl     = CTRL_RESET;
            mc_start = 1'b0;
            dm_start = 1'b0;
            dm_hold  = 1'b0;
            state_d  = RUN;
        end
    end

    assign reg_en = reg_enables(ctrl);
    assign {fd_en, de_en, em_en, mw_en} = reg_en;
    assign pc_en    = ctrl.pc_en;
    assign fd_flush = ctrl.fd_flush;
    assign de_flush = ctrl.de_flush;
    assign em_flush = ctrl.em_flush;

    pipe_seq_dm_timer #(
        .DM_TIMEOUT (DM_TIMEOUT)
    ) u_dm_timer (
        .clk         (clk),
        .rst         (rst),
        .start       (dm_start),
        .hold        (dm_hold),
        .timeout_err (dm_timeout_err)
    );

`ifdef PIPE_SEQ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!ctrl.pc_en && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (any_flush(ctrl) && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_ONE;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_pipeline_sequencer;

    localparam int unsigned DM_TIMEOUT = 64;
    localparam int unsigned CNT_W      = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             hz_stall_req = 1'b0;
    logic             ex_redirect = 1'b0;
    logic             ex_mc_op = 1'b0;
    logic             mc_done = 1'b0;
    logic             m_mem_req = 1'b0;
    logic             dm_ready = 1'b0;
    logic             mc_start;
    logic             pc_en, fd_en, de_en, em_en, mw_en;
    logic             fd_flush, de_flush, em_flush;
    logic             dm_timeout_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    int checks = 0;
    int fails  = 0;
    bit run_checks = 1'b1;

    // Behavioural model: which wait the pipeline is in, how long DM has been stalled.
    bit          m_dm_busy = 1'b0;
    bit          m_mc_busy = 1'b0;
    bit          m_err     = 1'b0;
    int unsigned m_dm_cnt  = 0;
`ifdef PIPE_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;
`endif

    pipeline_sequencer #(
        .DM_TIMEOUT (DM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hz_stall_req   (hz_stall_req),
        .ex_redirect    (ex_redirect),
        .ex_mc_op       (ex_mc_op),
        .mc_done        (mc_done),
        .m_mem_req      (m_mem_req),
        .dm_ready       (dm_ready),
        .mc_start       (mc_start),
        .pc_en          (pc_en),
        .fd_en          (fd_en),
        .de_en          (de_en),
        .em_en          (em_en),
        .mw_en          (mw_en),
        .fd_flush       (fd_flush),
        .de_flush       (de_flush),
        .em_flush       (em_flush),
        .dm_timeout_err (dm_timeout_err),
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {mc_start, pc,fd,de,em,mw enables, fd,de,em flushes} this cycle.
    function automatic logic [8:0] model_ctrl();
        if (rst)                         return 9'b0_11111_111;
        if (m_dm_busy && !dm_ready)      return 9'b0_00000_000;
        if (m_mc_busy && !mc_done)       return 9'b0_00011_001;
        if (m_mem_req && !dm_ready)      return 9'b0_00000_000;
        if (ex_mc_op && !m_mc_busy)      return 9'b1_00011_001;
        if (ex_redirect)                 return 9'b0_11111_110;
        if (hz_stall_req)                return 9'b0_00111_010;
        return 9'b0_11111_000;
    endfunction

    always @(posedge clk) begin : model_update
        logic [8:0]  e;
        int unsigned cnt;
        e   = model_ctrl();
        cnt = m_dm_cnt;
        if (rst) begin
            m_dm_busy <= 1'b0;
            m_mc_busy <= 1'b0;
            m_err     <= 1'b0;
            m_dm_cnt  <= 0;
`ifdef PIPE_SEQ_PERF_CNT_EN
            m_stall   <= '0;
            m_flush   <= '0;
`endif
        end else begin
            if (m_dm_busy && !dm_ready) begin
                if (cnt < DM_TIMEOUT) cnt = cnt + 1;
            end else if (!(m_mc_busy && !mc_done)) begin
                // A start pulse means the unit is now busy; a frozen pipe means DM stalled.
                m_mc_busy <= e[8];
                m_dm_busy <= (e[7:0] == 8'h00);
                if (e[7:0] == 8'h00) cnt = 1;
            end
            m_dm_cnt <= cnt;
            if (cnt >= DM_TIMEOUT) m_err <= 1'b1;
`ifdef PIPE_SEQ_PERF_CNT_EN
            if (!e[7] && (m_stall != '1)) m_stall <= m_stall + CNT_W'(1);
            if ((|e[2:0]) && (m_flush != '1)) m_flush <= m_flush + CNT_W'(1);
`endif
        end
    end

    always @(negedge clk) begin
        if (run_checks) begin
            check("ctrl", 64'({mc_start, pc_en, fd_en, de_en, em_en, mw_en,
                              fd_flush, de_flush, em_flush}), 64'(model_ctrl()));
            check("dm_timeout_err", 64'(dm_timeout_err), 64'(m_err));
`ifdef PIPE_SEQ_PERF_CNT_EN
            check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
            check("flush_events", 64'(flush_events), 64'(m_flush));
`else
            check("stall_cycles", 64'(stall_cycles), 64'd0);
            check("flush_events", 64'(flush_events), 64'd0);
`endif
        end
    end

    task automatic drive(input bit hz, input bit red, input bit mco,
                         input bit mcd, input bit mreq, input bit rdy);
        @(posedge clk); #1;
        hz_stall_req = hz;
        ex_redirect  = red;
        ex_mc_op     = mco;
        mc_done      = mcd;
        m_mem_req    = mreq;
        dm_ready     = rdy;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        int starts;
        int emf;
        int frozen;

        // Reset
        @(posedge clk); #1;
        settle();
        check("rst_ctrl", 64'({mc_start, pc_en, fd_en, de_en, em_en, mw_en,
                              fd_flush, de_flush, em_flush}), 64'h0FF);
        check("rst_err", 64'(dm_timeout_err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Load-use: one bubble
        drive(1, 0, 0, 0, 0, 0); settle();
        check("lu_stall", 64'({pc_en, fd_en, de_en, de_flush}), 64'b0011);
        drive(0, 0, 0, 0, 0, 0); settle();
        check("lu_resume", 64'({pc_en, fd_en, de_flush}), 64'b110);

        // Redirect overrides load-use
        drive(1, 1, 0, 0, 0, 0); settle();
        check("redir_flush", 64'({fd_flush, de_flush, pc_en, fd_en}), 64'b1111);
        drive(0, 0, 0, 0, 0, 0); settle();
`ifdef PIPE_SEQ_PERF_CNT_EN
        check("redir_flush_events", 64'(flush_events), 64'd2);
        check("lu_stall_cycles", 64'(stall_cycles), 64'd1);
`else
        check("redir_flush_events", 64'(flush_events), 64'd0);
`endif

        // Multi-cycle op, mc_done five cycles after the start
        starts = 0; emf = 0;
        repeat (5) begin
            drive(0, 0, 1, 0, 0, 0); settle();
            starts += int'(mc_start);
            emf    += int'(em_flush);
        end
        drive(0, 0, 1, 1, 0, 0); settle();
        starts += int'(mc_start);
        check("mc_done_cycle", 64'({em_en, em_flush, pc_en, mw_en}), 64'b1011);
        check("mc_start_once", 64'(starts), 64'd1);
        check("mc_em_flush_cnt", 64'(emf), 64'd5);
        drive(0, 0, 0, 0, 0, 0); settle();
        check("mc_back_run", 64'({pc_en, de_en, mc_start}), 64'b110);

        // DM stall takes priority over a waiting multi-cycle start
        starts = 0; frozen = 0;
        repeat (3) begin
            drive(0, 0, 1, 0, 1, 0); settle();
            starts += int'(mc_start);
            if ({pc_en, fd_en, de_en, em_en, mw_en} == 5'b00000) frozen++;
        end
        check("dm_frozen_cycles", 64'(frozen), 64'd3);
        check("dm_no_mc_start", 64'(starts), 64'd0);
        drive(0, 0, 1, 0, 1, 1); settle();
        check("dm_ready_mc_start", 64'(mc_start), 64'd1);
        drive(0, 0, 1, 1, 0, 0); settle();
        check("dm_mc_finish", 64'({pc_en, em_en, em_flush}), 64'b110);
        drive(0, 0, 0, 0, 0, 0);

        // DM timeout after DM_TIMEOUT stalled cycles; sticky until reset
        repeat (DM_TIMEOUT) drive(0, 0, 0, 0, 1, 0);
        settle();
        check("to_not_yet", 64'(dm_timeout_err), 64'd0);
        drive(0, 0, 0, 0, 1, 1); settle();
        check("to_set", 64'({dm_timeout_err, pc_en}), 64'b11);
        drive(0, 0, 0, 0, 0, 0); settle();
        check("to_sticky", 64'(dm_timeout_err), 64'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; settle();
        check("to_cleared", 64'(dm_timeout_err), 64'd0);

        // Reset in the middle of a multi-cycle wait
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0); settle();
        check("rmw_waiting", 64'({pc_en, em_flush, mc_start}), 64'b010);
        @(posedge clk); #1; rst = 1'b1; settle();
        check("rmw_rst_ctrl", 64'({mc_start, pc_en, fd_en, de_en, em_en, mw_en,
                                  fd_flush, de_flush, em_flush}), 64'h0FF);
        @(posedge clk); #1; rst = 1'b0; ex_mc_op = 1'b0; settle();
        check("rmw_run", 64'({pc_en, em_flush, mc_start}), 64'b100);
        check("rmw_stall_cnt", 64'(stall_cycles), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst          = ($urandom_range(0, 199) == 0);
            hz_stall_req = ($urandom_range(0, 3) == 0);
            ex_redirect  = ($urandom_range(0, 5) == 0);
            ex_mc_op     = m_mc_busy || ($urandom_range(0, 9) == 0);
            mc_done      = m_mc_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            m_mem_req    = m_mc_busy ? 1'b0 : (m_dm_busy || ($urandom_range(0, 3) == 0));
            dm_ready     = ($urandom_range(0, 2) != 0);
        end

        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        run_checks = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
